fpu_cmd_issuer: RTL and testbench
=================================

// Module: fpu_cmd_issuer
// PURPOSE
//  Synthesizable command front-end for the fpu core. Queues register-file commands
//  (operation, x1, x2, y, in_data) from a producer in a FIFO and issues them one at a
//  time over the fpu ready/valid handshake. Returns each result with a caller tag and
//  reports a timeout if the core never asserts valid. Sits between core/loader and fpu.
// PARAMETERS
//  DEPTH    8     command FIFO entries (power of 2, >=2)
//  OP_W     6     fpu operation code width
//  RA_W     5     register address width (x1/x2/y)
//  DATA_W   32    in_data / out_data32 width
//  TAG_W    4     caller tag width, returned unchanged with the result
//  TIMEOUT  1024  max cycles fpu_ready may stay high without fpu_valid; 0 = no timeout
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rstn           in   1       asynchronous active-low reset
//  cmd_valid      in   1       producer has a command
//  cmd_ready      out  1       FIFO can accept (count < DEPTH)
//  cmd_op         in   OP_W    operation code
//  cmd_x1/cmd_x2  in   RA_W    source registers
//  cmd_y          in   RA_W    destination register
//  cmd_data       in   DATA_W  immediate / in_data
//  cmd_tag        in   TAG_W   caller tag
//  fpu_ready      out  1       request to fpu (drives fpu .ready)
//  fpu_valid      in   1       fpu done (from fpu .valid)
//  fpu_operation  out  OP_W    to fpu .operation
//  fpu_x1/fpu_x2  out  RA_W    to fpu .x1/.x2
//  fpu_y          out  RA_W    to fpu .y
//  fpu_in_data    out  DATA_W  to fpu .in_data
//  fpu_out_data1  in   1       fpu compare result
//  fpu_out_data32 in   DATA_W  fpu data result
//  rsp_valid      out  1       result available
//  rsp_ready      in   1       consumer takes result
//  rsp_tag        out  TAG_W   tag of completed command
//  rsp_data1      out  1       captured out_data1
//  rsp_data32     out  DATA_W  captured out_data32
//  rsp_err        out  1       1 = command aborted by timeout
//  count          out  $clog2(DEPTH+1)  FIFO occupancy
//  busy           out  1       state != IDLE or count != 0
// BEHAVIOUR
//  Reset (async, rstn=0): state IDLE, FIFO empty, count=0, fpu_ready=0, rsp_valid=0,
//   rsp_err=0, all data/tag/fpu_* outputs 0; cmd_ready=1 after release. Reset mid-command
//   drops fpu_ready immediately and discards queued and in-flight commands; no response.
//  Push: cmd_valid & cmd_ready at edge -> entry written, count+1. cmd_ready depends on count
//   only (no pass-through when full). Push and pop on same edge: count unchanged.
//  FSM (registered outputs):
//   IDLE : count>0 -> pop head into issue regs (fpu_* outputs), fpu_ready<=1, -> ISSUE.
//   ISSUE: fpu_* held stable. fpu_valid=1 -> capture out_data1/out_data32, tag, err=0,
//          fpu_ready<=0, rsp_valid<=1, -> RESP. Else timer+1; timer==TIMEOUT-1 (TIMEOUT>0)
//          -> data 0, err=1, fpu_ready<=0, rsp_valid<=1, -> RESP. fpu_valid wins on tie.
//   RESP : rsp_* held stable while rsp_valid & !rsp_ready. rsp_ready -> rsp_valid<=0, -> IDLE.
//  Latency: command accepted at edge N -> fpu_ready high after edge N+1 (empty, IDLE).
//   fpu_valid at edge M -> rsp_valid high after M. fpu_ready low >= 2 cycles between cmds.
//  fpu_valid while not in ISSUE is ignored. Timer clears on entry to ISSUE.
//  FIFO pointers log2(DEPTH) bits, wrap naturally; count distinguishes full/empty.
// STRUCTURE
//  fpu_pkg: OP_W/RA_W/DATA_W defaults, opcode constants (OP_LOADI=6'b111110,
//   OP_LOADR=6'b111101, OP_OUT=6'b111000), typedef fpu_cmd_t {op,x1,x2,y,data,tag},
//   typedef enum {IDLE,ISSUE,RESP} issuer_state_t.
//  Sub-module fpu_cmd_fifo (sync FIFO of fpu_cmd_t, DEPTH, push/pop/count, async rstn);
//   FSM, timer and response regs stay in fpu_cmd_issuer.
// TESTING
//  1 Load-imm: op=6'b111110 y=0 data=32'hc0490fcf tag=3; fpu model valid 5 cyc later,
//    out_data32=32'hc0490fcf -> fpu_ready high 1 cyc after accept, rsp tag=3 err=0 data ok.
//  2 Back-to-back: 8 cmds tags 0..7, DEPTH=8, fpu stalled -> cmd_ready=0 at count=8, 9th
//    held; responses in tag order 0..7, fpu_ready low >=2 cyc between issues.
//  3 Timeout: TIMEOUT=16, fpu_valid never -> fpu_ready drops after 16 cyc, rsp_err=1, data 0;
//    next queued command still issues.
//  4 Backpressure: rsp_ready=0 for 10 cyc -> rsp_* stable, no new issue, FIFO keeps filling.
//  5 Reset mid-ISSUE: rstn=0 with 3 queued -> fpu_ready=0 same cycle, count=0, no rsp.
//  6 Simultaneous push+pop at count=DEPTH-1 and full: count correct, no loss/duplication.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the fpu command front-end.
package fpu_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned RA_W   = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 4;

    localparam logic [OP_W-1:0] OP_LOADI = 6'b111110;
    localparam logic [OP_W-1:0] OP_LOADR = 6'b111101;
    localparam logic [OP_W-1:0] OP_OUT   = 6'b111000;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [RA_W-1:0]   x1;
        logic [RA_W-1:0]   x2;
        logic [RA_W-1:0]   y;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } fpu_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } issuer_state_t;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO; occupancy count separates full from empty.
module fpu_cmd_fifo
    import fpu_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  fpu_cmd_t      push_data,
    input  logic          pop,
    output fpu_cmd_t      head,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    fpu_cmd_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign push_ok = push && (count != CW'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_cmd_issuer.sv
// Queues fpu register-file commands and issues them one at a time over the
// fpu ready/valid handshake, returning tagged results or a timeout error.
module fpu_cmd_issuer #(
    parameter  int unsigned DEPTH   = 8,
    parameter  int unsigned OP_W    = 6,
    parameter  int unsigned RA_W    = 5,
    parameter  int unsigned DATA_W  = 32,
    parameter  int unsigned TAG_W   = 4,
    parameter  int unsigned TIMEOUT = 1024,
    localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [RA_W-1:0]   cmd_x1,
    input  logic [RA_W-1:0]   cmd_x2,
    input  logic [RA_W-1:0]   cmd_y,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic              fpu_ready,
    input  logic              fpu_valid,
    output logic [OP_W-1:0]   fpu_operation,
    output logic [RA_W-1:0]   fpu_x1,
    output logic [RA_W-1:0]   fpu_x2,
    output logic [RA_W-1:0]   fpu_y,
    output logic [DATA_W-1:0] fpu_in_data,
    input  logic              fpu_out_data1,
    input  logic [DATA_W-1:0] fpu_out_data32,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_data1,
    output logic [DATA_W-1:0] rsp_data32,
    output logic              rsp_err,
    output logic [CW-1:0]     count,
    output logic              busy
);

    import fpu_pkg::*;

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    issuer_state_t     state, state_d;
    fpu_cmd_t          push_data, head, issue_q, issue_d;
    logic              pop;
    logic              fpu_ready_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              rsp_valid_d, rsp_err_d, rsp_data1_d;
    logic [TAG_W-1:0]  rsp_tag_d;
    logic [DATA_W-1:0] rsp_data32_d;

    assign cmd_ready = (count < CW'(DEPTH));
    assign push_data = '{op: cmd_op, x1: cmd_x1, x2: cmd_x2, y: cmd_y,
                         data: cmd_data, tag: cmd_tag};

    fpu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (cmd_valid && cmd_ready),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign fpu_operation = issue_q.op;
    assign fpu_x1        = issue_q.x1;
    assign fpu_x2        = issue_q.x2;
    assign fpu_y         = issue_q.y;
    assign fpu_in_data   = issue_q.data;
    assign busy          = (state != IDLE) || (count != '0);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d      = state;
        issue_d      = issue_q;
        pop          = 1'b0;
        fpu_ready_d  = fpu_ready;
        timer_d      = timer_q;
        rsp_valid_d  = rsp_valid;
        rsp_err_d    = rsp_err;
        rsp_tag_d    = rsp_tag;
        rsp_data1_d  = rsp_data1;
        rsp_data32_d = rsp_data32;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop         = 1'b1;
                    issue_d     = head;
                    fpu_ready_d = 1'b1;
                    timer_d     = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (fpu_valid) begin
                    rsp_data1_d  = fpu_out_data1;
                    rsp_data32_d = fpu_out_data32;
                    rsp_tag_d    = issue_q.tag;
                    rsp_err_d    = 1'b0;
                    fpu_ready_d  = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else if ((TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1))) begin
                    rsp_data1_d  = 1'b0;
                    rsp_data32_d = '0;
                    rsp_tag_d    = issue_q.tag;
                    rsp_err_d    = 1'b1;
                    fpu_ready_d  = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, issue registers, timer and response registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            issue_q    <= '0;
            fpu_ready  <= 1'b0;
            timer_q    <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_tag    <= '0;
            rsp_data1  <= 1'b0;
            rsp_data32 <= '0;
        end else begin
            state      <= state_d;
            issue_q    <= issue_d;
            fpu_ready  <= fpu_ready_d;
            timer_q    <= timer_d;
            rsp_valid  <= rsp_valid_d;
            rsp_err    <= rsp_err_d;
            rsp_tag    <= rsp_tag_d;
            rsp_data1  <= rsp_data1_d;
            rsp_data32 <= rsp_data32_d;
        end
    end

endmodule

// File: tb/tb_fpu_cmd_issuer.sv
// Self-checking bench for fpu_cmd_issuer: directed table, hand sequences
// and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_fpu_cmd_issuer;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [5:0]    cmd_op = '0;
    logic [4:0]    cmd_x1 = '0, cmd_x2 = '0, cmd_y = '0;
    logic [31:0]   cmd_data = '0;
    logic [3:0]    cmd_tag = '0;
    logic          fpu_ready;
    logic          fpu_valid;
    logic [5:0]    fpu_operation;
    logic [4:0]    fpu_x1, fpu_x2, fpu_y;
    logic [31:0]   fpu_in_data;
    logic          fpu_out_data1;
    logic [31:0]   fpu_out_data32;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [3:0]    rsp_tag;
    logic          rsp_data1;
    logic [31:0]   rsp_data32;
    logic          rsp_err;
    logic [CW-1:0] count;
    logic          busy;

    always #5 clk = ~clk;

    fpu_cmd_issuer #(
        .DEPTH   (DEPTH),
        .OP_W    (6),
        .RA_W    (5),
        .DATA_W  (32),
        .TAG_W   (4),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_x1         (cmd_x1),
        .cmd_x2         (cmd_x2),
        .cmd_y          (cmd_y),
        .cmd_data       (cmd_data),
        .cmd_tag        (cmd_tag),
        .fpu_ready      (fpu_ready),
        .fpu_valid      (fpu_valid),
        .fpu_operation  (fpu_operation),
        .fpu_x1         (fpu_x1),
        .fpu_x2         (fpu_x2),
        .fpu_y          (fpu_y),
        .fpu_in_data    (fpu_in_data),
        .fpu_out_data1  (fpu_out_data1),
        .fpu_out_data32 (fpu_out_data32),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_tag        (rsp_tag),
        .rsp_data1      (rsp_data1),
        .rsp_data32     (rsp_data32),
        .rsp_err        (rsp_err),
        .count          (count),
        .busy           (busy)
    );

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  x1, x2, y;
        logic [31:0] data;
        logic [3:0]  tag;
    } cmd_t;

    typedef struct {
        logic [3:0]  tag;
        logic        err;
        logic [31:0] d32;
        logic        d1;
    } rsp_t;

    typedef struct {
        string       name;
        cmd_t        c;
        int          delay;   // fpu cycles until valid; 0 = never
        logic        err;
        logic [31:0] d32;
        logic        d1;
        int          hi;      // cycles fpu_ready stays high
    } row_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- reference model / fpu model / scoreboard ----------------
    cmd_t        exp_q[$];
    rsp_t        rexp_q[$];
    int          delay_q[$];
    logic [3:0]  rsp_log[$];
    logic        err_log[$];
    cmd_t        cur;
    rsp_t        r;
    int          cur_delay = 0, hi_cnt = 0, low_run = 2;
    int          accepted = 0, responded = 0;
    logic        p_ready = 0, p_rv = 0, p_rr = 0, p_err = 0, p_d1 = 0;
    logic [3:0]  p_tag = '0;
    logic [31:0] p_d32 = '0;
    bit          timed_out;

    initial begin
        fpu_valid      = 1'b0;
        fpu_out_data1  = 1'b0;
        fpu_out_data32 = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                exp_q.delete();
                rexp_q.delete();
                delay_q.delete();
                p_ready = 0; p_rv = 0; p_rr = 0;
                hi_cnt = 0; low_run = 2;
                accepted = 0; responded = 0;
                fpu_valid = 1'b0;
            end else begin
                // a command was issued at the last edge
                if (fpu_ready && !p_ready) begin
                    chk("issue_gap_ge2", low_run >= 2, 1);
                    if (exp_q.size() == 0) fail("issue_without_cmd");
                    else cur = exp_q.pop_front();
                    cur_delay = (delay_q.size() != 0) ? delay_q.pop_front()
                                                      : int'($urandom_range(0, 20));
                    hi_cnt = 0;
                    low_run = 0;
                end
                if (fpu_ready) begin
                    chk("fpu_fields", {fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data},
                        {cur.op, cur.x1, cur.x2, cur.y, cur.data});
                    chk("no_issue_during_rsp", rsp_valid, 0);
                    hi_cnt++;
                    if (cur_delay != 0 && hi_cnt == cur_delay) begin
                        fpu_valid      = 1'b1;
                        fpu_out_data32 = cur.data ^ {27'b0, cur.y};
                        fpu_out_data1  = cur.x1[0];
                    end else begin
                        fpu_valid      = 1'b0;
                        fpu_out_data32 = $urandom;
                        fpu_out_data1  = 1'($urandom);
                    end
                end else begin
                    if (p_ready) begin
                        timed_out = (cur_delay == 0) || (cur_delay > TIMEOUT);
                        chk("fpu_ready_hi_cycles", hi_cnt, timed_out ? TIMEOUT : cur_delay);
                        r.tag = cur.tag;
                        r.err = timed_out;
                        r.d32 = timed_out ? 32'h0 : (cur.data ^ {27'b0, cur.y});
                        r.d1  = timed_out ? 1'b0 : cur.x1[0];
                        rexp_q.push_back(r);
                    end
                    low_run++;
                    // stray valids outside an issue must be ignored
                    fpu_valid      = ($urandom_range(0, 3) == 0);
                    fpu_out_data32 = $urandom;
                    fpu_out_data1  = 1'($urandom);
                end
                if (rsp_valid && !p_rv) begin
                    if (rexp_q.size() == 0) fail("rsp_unexpected");
                    else begin
                        r = rexp_q.pop_front();
                        chk("rsp_tag", rsp_tag, r.tag);
                        chk("rsp_err", rsp_err, r.err);
                        chk("rsp_data32", rsp_data32, r.d32);
                        chk("rsp_data1", rsp_data1, r.d1);
                    end
                    rsp_log.push_back(rsp_tag);
                    err_log.push_back(rsp_err);
                    responded++;
                end
                if (p_rv && !p_rr)
                    chk("rsp_hold", {rsp_valid, rsp_tag, rsp_err, rsp_data1, rsp_data32},
                        {1'b1, p_tag, p_err, p_d1, p_d32});
                chk("count", count, exp_q.size());
                chk("cmd_ready", cmd_ready, exp_q.size() < DEPTH);
                chk("busy", busy, (exp_q.size() != 0) || fpu_ready || rsp_valid);
                if (cmd_valid && cmd_ready) begin
                    exp_q.push_back('{cmd_op, cmd_x1, cmd_x2, cmd_y, cmd_data, cmd_tag});
                    accepted++;
                end
                p_ready = fpu_ready;
                p_rv = rsp_valid; p_rr = rsp_ready;
                p_tag = rsp_tag; p_err = rsp_err; p_d1 = rsp_data1; p_d32 = rsp_data32;
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic drive_cmd(input cmd_t c);
        cmd_op = c.op; cmd_x1 = c.x1; cmd_x2 = c.x2; cmd_y = c.y;
        cmd_data = c.data; cmd_tag = c.tag;
    endtask

    task automatic push_cmd(input cmd_t c);
        logic acc;
        drive_cmd(c);
        cmd_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            acc = cmd_ready;
            @(posedge clk); #1;
            if (acc) begin
                cmd_valid = 1'b0;
                return;
            end
        end
        cmd_valid = 1'b0;
        fail("push_timeout");
    endtask

    task automatic wait_idle(input int maxc);
        for (int n = 0; n < maxc; n++) begin
            if (!busy && !rsp_valid && !fpu_ready) return;
            @(posedge clk); #1;
        end
        fail("idle_timeout");
    endtask

    function automatic cmd_t mk(input logic [3:0] tag, input logic [31:0] data);
        cmd_t c;
        c = '{6'h05, 5'd1, 5'd2, tag + 5'd3, data, tag};
        return c;
    endfunction

    task automatic run_row(input row_t rw);
        int hi;
        delay_q.push_back(rw.delay);
        push_cmd(rw.c);
        chk({rw.name, "_ready_before"}, fpu_ready, 0);
        @(posedge clk); #1;
        chk({rw.name, "_ready_lat1"}, fpu_ready, 1);
        hi = 0;
        for (int n = 0; n < 64 && fpu_ready; n++) begin
            hi++;
            @(posedge clk); #1;
        end
        chk({rw.name, "_hi"}, hi, rw.hi);
        chk({rw.name, "_rsp_valid"}, rsp_valid, 1);
        chk({rw.name, "_tag"}, rsp_tag, rw.c.tag);
        chk({rw.name, "_err"}, rsp_err, rw.err);
        chk({rw.name, "_d32"}, rsp_data32, rw.d32);
        chk({rw.name, "_d1"}, rsp_data1, rw.d1);
        wait_idle(20);
    endtask

    row_t rows[6];
    int   base;

    initial begin
        rows[0] = '{"loadi",  '{6'b111110, 5'd0, 5'd0, 5'd0,  32'hc0490fcf, 4'd3},  5, 1'b0, 32'hc0490fcf, 1'b0, 5};
        rows[1] = '{"loadr",  '{6'b111101, 5'd3, 5'd0, 5'd7,  32'h00001234, 4'd9},  1, 1'b0, 32'h00001233, 1'b1, 1};
        rows[2] = '{"tie",    '{6'b111000, 5'd2, 5'd0, 5'd31, 32'hffffffff, 4'd15}, 16, 1'b0, 32'hffffffe0, 1'b0, 16};
        rows[3] = '{"late",   '{6'h01,     5'd5, 5'd0, 5'd4,  32'hdeadbeef, 4'd0},  17, 1'b1, 32'h0,        1'b0, 16};
        rows[4] = '{"never",  '{6'h02,     5'd1, 5'd0, 5'd1,  32'h00000001, 4'd7},  0, 1'b1, 32'h0,        1'b0, 16};
        rows[5] = '{"early",  '{6'h10,     5'd1, 5'd9, 5'd2,  32'h80000000, 4'd12}, 15, 1'b0, 32'h80000002, 1'b1, 15};

        // reset state
        #1 rstn = 1'b0;
        #1;
        chk("rst_ready_valid_err", {fpu_ready, rsp_valid, rsp_err, rsp_data1, busy}, 0);
        chk("rst_rsp_data_tag", {rsp_tag, rsp_data32}, 0);
        chk("rst_fpu_fields", {fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data}, 0);
        chk("rst_count", count, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        chk("rel_cmd_ready", cmd_ready, 1);

        // directed single-command table
        foreach (rows[i]) run_row(rows[i]);

        // back-to-back fill with response backpressure, then push at full
        rsp_ready = 1'b0;
        rsp_log.delete();
        for (int i = 0; i < 10; i++) delay_q.push_back(3);
        for (int i = 0; i < 9; i++) push_cmd(mk(4'(i), 32'h100 + i));
        chk("full_count", count, DEPTH);
        chk("full_cmd_ready", cmd_ready, 0);
        drive_cmd(mk(4'd9, 32'h109));
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_count", count, DEPTH);
            chk("bp_no_issue", fpu_ready, 0);
            chk("bp_rsp_tag", {rsp_valid, rsp_tag}, {1'b1, 4'd0});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("full_e1_count", count, DEPTH);
        @(posedge clk); #1;
        chk("full_pop_count", count, DEPTH - 1);
        chk("full_pop_issue", fpu_ready, 1);
        @(posedge clk); #1;
        chk("full_refill_count", count, DEPTH);
        cmd_valid = 1'b0;
        wait_idle(400);
        chk("order_size", rsp_log.size(), 10);
        for (int i = 0; i < 10 && i < rsp_log.size(); i++) chk("order_tag", rsp_log[i], i);

        // push and pop on the same edge at count = DEPTH-1
        rsp_ready = 1'b0;
        rsp_log.delete();
        for (int i = 0; i < 9; i++) delay_q.push_back(1);
        for (int i = 0; i < 8; i++) push_cmd(mk(4'(i), 32'h200 + i));
        for (int n = 0; n < 10 && !rsp_valid; n++) begin @(posedge clk); #1; end
        chk("pp_count_pre", count, DEPTH - 1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("pp_idle", {rsp_valid, fpu_ready}, 0);
        push_cmd(mk(4'd8, 32'h208));
        chk("pp_count_post", count, DEPTH - 1);
        chk("pp_issue", fpu_ready, 1);
        wait_idle(400);
        chk("pp_order_size", rsp_log.size(), 9);
        for (int i = 0; i < 9 && i < rsp_log.size(); i++) chk("pp_order_tag", rsp_log[i], i);

        // timeout followed by a normally completing queued command
        base = err_log.size();
        delay_q.push_back(0);
        delay_q.push_back(4);
        push_cmd(mk(4'd1, 32'h301));
        push_cmd(mk(4'd2, 32'h302));
        wait_idle(100);
        chk("to_resp_count", err_log.size() - base, 2);
        if (err_log.size() - base == 2) begin
            chk("to_first_err", err_log[base], 1);
            chk("to_second_err", err_log[base + 1], 0);
        end

        // reset while a command is in flight with three queued
        delay_q.push_back(0);
        for (int i = 0; i < 4; i++) push_cmd(mk(4'(i), 32'h400 + i));
        for (int n = 0; n < 20 && !(fpu_ready && count == 3); n++) begin @(posedge clk); #1; end
        chk("mid_setup", {fpu_ready, count}, {1'b1, CW'(3)});
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_ready", fpu_ready, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            chk("post_rst_quiet", {rsp_valid, fpu_ready, busy}, 0);
        end

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            cmd_valid = ($urandom_range(0, 99) < 45);
            cmd_op = 6'($urandom); cmd_x1 = 5'($urandom); cmd_x2 = 5'($urandom);
            cmd_y = 5'($urandom); cmd_data = $urandom; cmd_tag = 4'($urandom);
            rsp_ready = ($urandom_range(0, 99) < 70);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle(3000);
        chk("rand_all_responded", responded, accepted);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        errors++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
